// File: rtl/tft_cmd_seq_if.sv
// Bus bundle for tft_cmd_seq: sequence-memory load, run control,
// window corners and the downstream byte-transmitter handshake.
interface tft_cmd_seq_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W+1:0] rom_wdata;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              abort;
    logic              win_start;
    logic [15:0]       win_x0;
    logic [15:0]       win_x1;
    logic [15:0]       win_y0;
    logic [15:0]       win_y1;
    logic              tft_busy;
    logic              tft_dc;
    logic [DATA_W-1:0] tft_data;
    logic              tft_transmit;
    logic              busy;
    logic              done;

    // Controller side (drives the sequencer)
    modport master (
        output rom_we, rom_addr, rom_wdata, start, start_addr, abort,
               win_start, win_x0, win_x1, win_y0, win_y1, tft_busy,
        input  tft_dc, tft_data, tft_transmit, busy, done
    );

    // Sequencer side
    modport slave (
        input  rom_we, rom_addr, rom_wdata, start, start_addr, abort,
               win_start, win_x0, win_x1, win_y0, win_y1, tft_busy,
        output tft_dc, tft_data, tft_transmit, busy, done
    );
endinterface

// File: rtl/tft_cmd_seq.sv
// TFT command sequencer: plays a program of COMM/DATA/WAIT/END entries from
// an internal memory into a byte transmitter, one handshaked byte at a time.
// Optional window-select burst (CASET/PASET/RAMWR) when the macro
// TFT_CMD_SEQ_WINDOW_EN is defined; otherwise win_start and corners are ignored.
module tft_cmd_seq #(
    parameter int unsigned ROM_DEPTH    = 64,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TICKS_PER_MS = 27000
) (
    input  logic         clk,
    input  logic         rst_n,
    tft_cmd_seq_if.slave bus
);
    localparam int unsigned ADDR_W  = $clog2(ROM_DEPTH);
    localparam int unsigned ENTRY_W = DATA_W + 2;
    localparam int unsigned WAIT_W  = DATA_W + $clog2(TICKS_PER_MS + 1);

    localparam logic [1:0]        T_WAIT   = 2'b10;
    localparam logic [1:0]        T_END    = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        HOLD    = 3'd3,
        WAIT_MS = 3'd4,
        DONE    = 3'd5
`ifdef TFT_CMD_SEQ_WINDOW_EN
        , WIN   = 3'd6
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ENTRY_W-1:0]  entry_q;
    logic                tx_q, tx_d;
    logic                dc_q, dc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic                busy_q;
    logic                advance;
    logic [ENTRY_W-1:0]  mem [ROM_DEPTH];

    logic [1:0]          ent_type;
    logic [DATA_W-1:0]   ent_payload;

    assign ent_type    = entry_q[ENTRY_W-1:DATA_W];
    assign ent_payload = entry_q[DATA_W-1:0];

`ifdef TFT_CMD_SEQ_WINDOW_EN
    logic [15:0] x0_q, x1_q, y0_q, y1_q;
    logic [3:0]  win_idx_q, win_idx_d;
    logic        burst_q, burst_d;
    logic        win_dc_c;
    logic [7:0]  win_byte_c;
    logic        win_go_c;

    assign win_go_c = (state_q == IDLE) && bus.win_start && !bus.start;

    // Corners are captured at win_start so later changes don't tear the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
        end else if (win_go_c) begin
            x0_q <= bus.win_x0;
            x1_q <= bus.win_x1;
            y0_q <= bus.win_y0;
            y1_q <= bus.win_y1;
        end
    end

    // Burst byte selection: 2A x0 x1, 2B y0 y1, 2C
    always_comb begin
        win_dc_c   = 1'b1;
        win_byte_c = 8'h00;
        case (win_idx_q)
            4'd0:    begin win_dc_c = 1'b0; win_byte_c = 8'h2A; end
            4'd1:    win_byte_c = x0_q[15:8];
            4'd2:    win_byte_c = x0_q[7:0];
            4'd3:    win_byte_c = x1_q[15:8];
            4'd4:    win_byte_c = x1_q[7:0];
            4'd5:    begin win_dc_c = 1'b0; win_byte_c = 8'h2B; end
            4'd6:    win_byte_c = y0_q[15:8];
            4'd7:    win_byte_c = y0_q[7:0];
            4'd8:    win_byte_c = y1_q[15:8];
            4'd9:    win_byte_c = y1_q[7:0];
            default: begin win_dc_c = 1'b0; win_byte_c = 8'h2C; end
        endcase
    end
`else
    logic unused_win;
    assign unused_win = ^{bus.win_start, bus.win_x0, bus.win_x1, bus.win_y0, bus.win_y1};
`endif

    // Sequence memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.rom_we) begin
            mem[bus.rom_addr] <= bus.rom_wdata;
        end
    end

    // Current entry: sampled only in FETCH (or WIN) so writes land on the next fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (state_q == FETCH) begin
            entry_q <= mem[index_q];
        end
`ifdef TFT_CMD_SEQ_WINDOW_EN
        else if (state_q == WIN) begin
            entry_q <= {1'b0, win_dc_c, DATA_W'(win_byte_c)};
        end
`endif
    end

    // State and registered-output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            wait_q    <= '0;
            tx_q      <= 1'b0;
            dc_q      <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TFT_CMD_SEQ_WINDOW_EN
            win_idx_q <= '0;
            burst_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            wait_q    <= wait_d;
            tx_q      <= tx_d;
            dc_q      <= dc_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= (state_d != IDLE);
`ifdef TFT_CMD_SEQ_WINDOW_EN
            win_idx_q <= win_idx_d;
            burst_q   <= burst_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        wait_d    = wait_q;
        tx_d      = 1'b0;
        dc_d      = dc_q;
        data_d    = data_q;
        done_d    = 1'b0;
        advance   = 1'b0;
`ifdef TFT_CMD_SEQ_WINDOW_EN
        win_idx_d = win_idx_q;
        burst_d   = burst_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    index_d = bus.start_addr;
                    state_d = FETCH;
`ifdef TFT_CMD_SEQ_WINDOW_EN
                    burst_d = 1'b0;
                end else if (bus.win_start) begin
                    win_idx_d = '0;
                    burst_d   = 1'b1;
                    state_d   = WIN;
`endif
                end
            end
            FETCH: state_d = ISSUE;
`ifdef TFT_CMD_SEQ_WINDOW_EN
            WIN:   state_d = ISSUE;
`endif
            ISSUE: begin
                case (ent_type)
                    T_WAIT: begin
                        wait_d  = WAIT_W'(ent_payload) * WAIT_W'(TICKS_PER_MS);
                        state_d = WAIT_MS;
                    end
                    T_END: state_d = DONE;
                    default: begin
                        if (!bus.tft_busy) begin
                            tx_d    = 1'b1;
                            dc_d    = ent_type[0];
                            data_d  = ent_payload;
                            state_d = HOLD;
                        end
                    end
                endcase
            end
            HOLD: advance = !bus.tft_busy;
            WAIT_MS: begin
                if (wait_q == '0) begin
                    advance = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
`ifdef TFT_CMD_SEQ_WINDOW_EN
            if (burst_q) begin
                if (win_idx_q == 4'd10) begin
                    state_d = DONE;
                end else begin
                    win_idx_d = win_idx_q + 4'd1;
                    state_d   = WIN;
                end
            end else
`endif
            if (index_q == LAST_IDX) begin
                state_d = DONE;
            end else begin
                index_d = index_q + ADDR_W'(1);
                state_d = FETCH;
            end
        end

        if (bus.abort) begin
            state_d = IDLE;
            tx_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign bus.tft_transmit = tx_q;
    assign bus.tft_dc       = dc_q;
    assign bus.tft_data     = data_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/tft_cmd_seq.md
TFT_CMD_SEQ -- requirements
Module: tft_cmd_seq

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 64, meaning number of sequence entries (power of 2, >=4).
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload and tft_data width.
REQ-003 SHALL have parameter TICKS_PER_MS, default 27000, meaning clk cycles per 1 ms wait unit.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port rom_we  in  1  sequence-memory write strobe.
REQ-007 SHALL have port rom_addr  in  log2(ROM_DEPTH)  write address.
REQ-008 SHALL have port rom_wdata  in  DATA_W+2  entry {type[1:0], payload}; type 00 COMM, 01 DATA, 10 WAIT, 11 END.
REQ-009 SHALL have port start  in  1  one-cycle pulse; begin program at start_addr.
REQ-010 SHALL have port start_addr  in  log2(ROM_DEPTH)  first entry index.
REQ-011 SHALL have port abort  in  1  one-cycle pulse; stop the current run.
REQ-012 SHALL have port win_start  in  1  one-cycle pulse; emit window-select burst.
REQ-013 SHALL have ports win_x0, win_x1, win_y0, win_y1  in  16 each  inclusive window corners.
REQ-014 SHALL have port tft_busy  in  1  downstream byte transmitter busy.
REQ-015 SHALL have ports tft_dc  out  1 (0 command, 1 data), tft_data  out  DATA_W, tft_transmit  out  1 (one-cycle pulse).
REQ-016 SHALL have ports busy  out  1 (run or burst active) and done  out  1 (one-cycle pulse on normal completion).

Function
REQ-017 SHALL implement states IDLE, FETCH, ISSUE, HOLD, WAIT_MS, WIN, DONE.
REQ-018 SHALL write rom_wdata at rom_addr on rising edge when rom_we=1, in any state; a write to the entry currently being fetched SHALL be visible no earlier than the next fetch.
REQ-019 SHALL read memory synchronously: FETCH lasts exactly one cycle, then ISSUE.
REQ-020 In IDLE, start SHALL latch start_addr into index and go to FETCH; win_start SHALL go to WIN; if both, start wins and win_start is dropped.
REQ-021 In ISSUE, COMM/DATA SHALL drive tft_transmit=1 for exactly one cycle with tft_dc=type[0], tft_data=payload, only when tft_busy=0; otherwise remain in ISSUE.
REQ-022 After a transmit pulse, SHALL spend one cycle in HOLD, then advance index and FETCH once tft_busy=0.
REQ-023 WAIT SHALL stall payload*TICKS_PER_MS cycles (+/-1) in WAIT_MS with no transmit; payload 0 SHALL advance after one cycle.
REQ-024 END SHALL go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-025 Index SHALL be ROM_DEPTH-1 max; advancing past ROM_DEPTH-1 without END SHALL go to DONE (no wrap).
REQ-026 WIN SHALL emit, via the ISSUE/HOLD handshake: COMM 2A, DATA x0[15:8], x0[7:0], x1[15:8], x1[7:0], COMM 2B, same for y0/y1, COMM 2C — 11 transfers — then DONE; corners SHALL be latched at win_start.
REQ-027 When DATA_W>8, burst payloads SHALL be zero-extended bytes.
REQ-028 abort SHALL return to IDLE next cycle from any state without pulsing done; a transmit already pulsed is not retracted.
REQ-029 start/win_start while busy=1 SHALL be ignored.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 On rst_n=0, SHALL asynchronously enter IDLE with tft_transmit=0, tft_dc=0, tft_data=0, busy=0, done=0, index=0, wait counter=0.
REQ-032 Memory contents SHALL NOT be cleared by reset; reset mid-run SHALL abandon the run with no further transmit.

Configuration
REQ-033 Macro TFT_CMD_SEQ_WINDOW_EN defined: REQ-026 window burst compiled in.
REQ-034 Macro undefined: WIN state and corner registers absent, win_start and win_* ignored, ports retained.

Verification
REQ-035 Load {COMM 11},{WAIT 2},{COMM 29},{END} at 0, start_addr=0, tft_busy held 0 -> transmits 0x11 dc=0, gap >=2*TICKS_PER_MS cycles, 0x29 dc=0, done pulse, busy=0.
REQ-036 Load {COMM 2C},{DATA 55} at 62-63, no END, start_addr=62 -> two transmits, done pulse, index not wrapped to 0.
REQ-037 win_start, x0=0, x1=319, y0=0, y1=479 -> 2A,00,00,01,3F,2B,00,00,01,DF,2C with dc 0,1,1,1,1,0,1,1,1,1,0.
REQ-038 tft_busy held 1 for 20 cycles after each pulse -> exactly one pulse per entry, next pulse >=1 cycle after tft_busy falls.
REQ-039 abort during WAIT_MS of 255 -> IDLE next cycle, no done, no transmit; rst_n low mid-burst -> all outputs 0 immediately.
